// File: rtl/hash_table_pkg.sv
// Shared types and the bucket index hash for the hash table engines.
package hash_table_pkg;

    // Upper bounds for the generic hash helper; callers cast in and out.
    localparam int unsigned MAX_KEY_W = 64;
    localparam int unsigned MAX_IDX_W = 32;

    // Default field widths used for the canonical slot layout.
    localparam int unsigned DEF_KEY_W = 32;
    localparam int unsigned DEF_VAL_W = 32;

    typedef enum logic [3:0] {
        OpSearch = 4'd1,
        OpInsert = 4'd2,
        OpDelete = 4'd3
    } opcode_e;

    typedef enum logic [4:0] {
        ResNone          = 5'd0,
        ResSearchFound   = 5'd1,
        ResSearchMiss    = 5'd2,
        ResInsertOk      = 5'd3,
        ResInsertUpdated = 5'd4,
        ResInsertFull    = 5'd5,
        ResDeleteOk      = 5'd6,
        ResDeleteMiss    = 5'd7,
        ResBadOpcode     = 5'd8
    } rescode_e;

    // One bucket slot; a bucket word is NUM_SLOTS of these, slot 0 in the LSBs.
    typedef struct packed {
        logic                 valid;
        logic [DEF_KEY_W-1:0] key;
        logic [DEF_VAL_W-1:0] val;
    } slot_t;

    // XOR-fold of all idx_w-bit chunks of the low key_w key bits; the top chunk is
    // implicitly zero-padded. Only the low idx_w bits of the result are meaningful.
    function automatic logic [MAX_IDX_W-1:0] hash_idx(input logic [MAX_KEY_W-1:0] key,
                                                      input int unsigned         idx_w,
                                                      input int unsigned         key_w);
        logic [MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < MAX_KEY_W; i++) begin
            if (i < key_w) begin
                idx[i % idx_w] = idx[i % idx_w] ^ key[i];
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/hash_table_bucket_ram.sv
// Simple dual-port bucket RAM: one write port, one registered read port.
module hash_table_bucket_ram #(
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned WIDTH  = 260
) (
    input  logic              clock,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port; the array has no reset, the engine sweeps it instead.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port with one cycle of latency.
    always_ff @(posedge clock) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/hash_table_bucket_engine.sv
// Single-partition bucketed hash table: search, insert-or-update, delete.
module hash_table_bucket_engine
    import hash_table_pkg::*;
#(
    parameter int unsigned NUM_ENTRIES   = 1024,
    parameter int unsigned NUM_SLOTS     = 4,
    parameter int unsigned KEY_WIDTH     = 32,
    parameter int unsigned VAL_WIDTH     = 32,
    parameter int unsigned OPCODE_WIDTH  = 4,
    parameter int unsigned RESCODE_WIDTH = 5
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_input_valid,
    output logic                     in_input_ready,
    input  logic [OPCODE_WIDTH-1:0]  in_opcode,
    input  logic [KEY_WIDTH-1:0]     in_key,
    input  logic [VAL_WIDTH-1:0]     in_wr_data,
    output logic                     out_output_valid,
    input  logic                     out_output_ready,
    output logic [VAL_WIDTH-1:0]     out_val_out,
    output logic [KEY_WIDTH-1:0]     out_key,
    output logic [RESCODE_WIDTH-1:0] out_rescode,
    output logic                     status_init_done
);

    localparam int unsigned IDX_W      = $clog2(NUM_ENTRIES);
    localparam int unsigned SLOT_W     = 1 + KEY_WIDTH + VAL_WIDTH;
    localparam int unsigned WORD_W     = NUM_SLOTS * SLOT_W;
    localparam int unsigned SLOT_IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

    typedef enum logic [2:0] {
        StInit,
        StIdle,
        StRd,
        StCmp,
        StResp
    } state_e;

    state_e state_q, state_d;

    logic [IDX_W-1:0]         init_cnt_q;
    logic                     init_done_q;
    logic [OPCODE_WIDTH-1:0]  op_q;
    logic [KEY_WIDTH-1:0]     key_q;
    logic [VAL_WIDTH-1:0]     data_q;
    logic [VAL_WIDTH-1:0]     resp_val_q;
    logic [KEY_WIDTH-1:0]     resp_key_q;
    logic [RESCODE_WIDTH-1:0] resp_code_q;

    logic             accept;
    logic             op_legal;
    logic [IDX_W-1:0] idx;

    logic              ram_rd_en;
    logic [WORD_W-1:0] ram_rd_data;
    logic              ram_wr_en;
    logic [IDX_W-1:0]  ram_wr_addr;
    logic [WORD_W-1:0] ram_wr_data;

    logic [NUM_SLOTS-1:0] slot_valid;
    logic [KEY_WIDTH-1:0] slot_key [NUM_SLOTS];
    logic [VAL_WIDTH-1:0] slot_val [NUM_SLOTS];

    logic                  hit_any;
    logic [SLOT_IDX_W-1:0] hit_sel;
    logic                  free_any;
    logic [SLOT_IDX_W-1:0] free_sel;

    logic [WORD_W-1:0]    cmp_word;
    logic                 cmp_we;
    rescode_e             cmp_code;
    logic [VAL_WIDTH-1:0] cmp_val;

    assign in_input_ready   = (state_q == StIdle);
    assign out_output_valid = (state_q == StResp);
    assign out_val_out      = resp_val_q;
    assign out_key          = resp_key_q;
    assign out_rescode      = resp_code_q;
    assign status_init_done = init_done_q;

    assign accept   = in_input_ready && in_input_valid;
    assign op_legal = (op_q == OPCODE_WIDTH'(OpSearch)) || (op_q == OPCODE_WIDTH'(OpInsert)) ||
                      (op_q == OPCODE_WIDTH'(OpDelete));
    assign idx      = IDX_W'(hash_idx(MAX_KEY_W'(key_q), IDX_W, KEY_WIDTH));

    // Illegal opcodes never touch the RAM; a write-back coinciding with reset is dropped.
    assign ram_rd_en   = (state_q == StRd) && op_legal;
    assign ram_wr_en   = (state_q == StInit) || ((state_q == StCmp) && cmp_we && !reset);
    assign ram_wr_addr = (state_q == StInit) ? init_cnt_q : idx;
    assign ram_wr_data = (state_q == StInit) ? '0 : cmp_word;

    hash_table_bucket_ram #(
        .DEPTH  (NUM_ENTRIES),
        .ADDR_W (IDX_W),
        .WIDTH  (WORD_W)
    ) u_ram (
        .clock   (clock),
        .rd_en   (ram_rd_en),
        .rd_addr (idx),
        .rd_data (ram_rd_data),
        .wr_en   (ram_wr_en),
        .wr_addr (ram_wr_addr),
        .wr_data (ram_wr_data)
    );

    // Split the bucket word into slot fields ({valid, key, val}, slot 0 in the LSBs).
    always_comb begin
        for (int i = 0; i < int'(NUM_SLOTS); i++) begin
            slot_valid[i] = ram_rd_data[i*SLOT_W + SLOT_W - 1];
            slot_key[i]   = ram_rd_data[i*SLOT_W + VAL_WIDTH +: KEY_WIDTH];
            slot_val[i]   = ram_rd_data[i*SLOT_W +: VAL_WIDTH];
        end
    end

    // Lowest-index matching slot and lowest-index free slot.
    always_comb begin
        hit_any  = 1'b0;
        hit_sel  = '0;
        free_any = 1'b0;
        free_sel = '0;
        for (int i = int'(NUM_SLOTS) - 1; i >= 0; i--) begin
            if (slot_valid[i] && (slot_key[i] == key_q)) begin
                hit_any = 1'b1;
                hit_sel = SLOT_IDX_W'(i);
            end
            if (!slot_valid[i]) begin
                free_any = 1'b1;
                free_sel = SLOT_IDX_W'(i);
            end
        end
    end

    // Result code, returned value and single write-back word for the compare cycle.
    always_comb begin
        cmp_word = ram_rd_data;
        cmp_we   = 1'b0;
        cmp_code = ResNone;
        cmp_val  = '0;
        if (op_q == OPCODE_WIDTH'(OpSearch)) begin
            if (hit_any) begin
                cmp_code = ResSearchFound;
                cmp_val  = slot_val[hit_sel];
            end else begin
                cmp_code = ResSearchMiss;
            end
        end else if (op_q == OPCODE_WIDTH'(OpInsert)) begin
            if (hit_any) begin
                cmp_word[hit_sel*SLOT_W +: VAL_WIDTH] = data_q;
                cmp_we   = 1'b1;
                cmp_code = ResInsertUpdated;
            end else if (free_any) begin
                cmp_word[free_sel*SLOT_W +: SLOT_W] = {1'b1, key_q, data_q};
                cmp_we   = 1'b1;
                cmp_code = ResInsertOk;
            end else begin
                cmp_code = ResInsertFull;
            end
        end else if (op_q == OPCODE_WIDTH'(OpDelete)) begin
            if (hit_any) begin
                cmp_word[hit_sel*SLOT_W + SLOT_W - 1] = 1'b0;
                cmp_we   = 1'b1;
                cmp_code = ResDeleteOk;
            end else begin
                cmp_code = ResDeleteMiss;
            end
        end else begin
            cmp_code = ResBadOpcode;
        end
    end

    // Next-state logic; illegal opcodes still walk RD and CMP for uniform latency.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StInit: if (init_cnt_q == LAST_IDX) state_d = StIdle;
            StIdle: if (accept) state_d = StRd;
            StRd:   state_d = StCmp;
            StCmp:  state_d = StResp;
            StResp: if (out_output_ready) state_d = StIdle;
            default: state_d = StInit;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StInit;
        end else begin
            state_q <= state_d;
        end
    end

    // Init sweep counter and done flag; reset restarts the sweep from address 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            init_cnt_q  <= '0;
            init_done_q <= 1'b0;
        end else if (state_q == StInit) begin
            init_cnt_q <= init_cnt_q + 1'b1;
            if (init_cnt_q == LAST_IDX) begin
                init_done_q <= 1'b1;
            end
        end
    end

    // Request capture on accept.
    always_ff @(posedge clock) begin
        if (reset) begin
            op_q   <= '0;
            key_q  <= '0;
            data_q <= '0;
        end else if (accept) begin
            op_q   <= in_opcode;
            key_q  <= in_key;
            data_q <= in_wr_data;
        end
    end

    // Response registers, loaded at the end of the compare cycle and held through RESP.
    always_ff @(posedge clock) begin
        if (reset) begin
            resp_val_q  <= '0;
            resp_key_q  <= '0;
            resp_code_q <= '0;
        end else if (state_q == StCmp) begin
            resp_val_q  <= cmp_val;
            resp_key_q  <= key_q;
            resp_code_q <= RESCODE_WIDTH'(cmp_code);
        end
    end

endmodule

// File: tb/tb_hash_table_bucket_engine.sv
// Self-checking bench: directed scenarios plus randomized traffic against a key/value model.
module tb_hash_table_bucket_engine;

    localparam int unsigned NE = 1024;
    localparam int unsigned NS = 4;

    localparam logic [3:0] OP_S = 4'd1, OP_I = 4'd2, OP_D = 4'd3;
    localparam logic [4:0] R_FOUND = 5'd1, R_SMISS = 5'd2, R_IOK = 5'd3, R_IUPD = 5'd4,
                           R_IFULL = 5'd5, R_DOK = 5'd6, R_DMISS = 5'd7, R_BAD = 5'd8;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_input_valid;
    logic        in_input_ready;
    logic [3:0]  in_opcode;
    logic [31:0] in_key;
    logic [31:0] in_wr_data;
    logic        out_output_valid;
    logic        out_output_ready;
    logic [31:0] out_val_out;
    logic [31:0] out_key;
    logic [4:0]  out_rescode;
    logic        status_init_done;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: stored key -> value, and number of keys living in each bucket.
    int unsigned mval [int unsigned];
    int unsigned bcnt [int unsigned];

    always #5 clock = ~clock;

    hash_table_bucket_engine #(
        .NUM_ENTRIES   (NE),
        .NUM_SLOTS     (NS),
        .KEY_WIDTH     (32),
        .VAL_WIDTH     (32),
        .OPCODE_WIDTH  (4),
        .RESCODE_WIDTH (5)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .in_input_valid   (in_input_valid),
        .in_input_ready   (in_input_ready),
        .in_opcode        (in_opcode),
        .in_key           (in_key),
        .in_wr_data       (in_wr_data),
        .out_output_valid (out_output_valid),
        .out_output_ready (out_output_ready),
        .out_val_out      (out_val_out),
        .out_key          (out_key),
        .out_rescode      (out_rescode),
        .status_init_done (status_init_done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int unsigned model_hash(input int unsigned key);
        int unsigned h = 0;
        int unsigned k = key;
        while (k != 0) begin
            h = h ^ (k % NE);
            k = k / NE;
        end
        return h;
    endfunction

    task automatic model_apply(input logic [3:0] op, input int unsigned k, input int unsigned d,
                               output logic [4:0] rc, output logic [31:0] v);
        int unsigned b = model_hash(k);
        int unsigned c = bcnt.exists(b) ? bcnt[b] : 0;
        v = '0;
        case (op)
            OP_S: begin
                if (mval.exists(k)) begin rc = R_FOUND; v = mval[k]; end
                else rc = R_SMISS;
            end
            OP_I: begin
                if (mval.exists(k)) begin rc = R_IUPD; mval[k] = d; end
                else if (c < NS) begin rc = R_IOK; mval[k] = d; bcnt[b] = c + 1; end
                else rc = R_IFULL;
            end
            OP_D: begin
                if (mval.exists(k)) begin rc = R_DOK; mval.delete(k); bcnt[b] = c - 1; end
                else rc = R_DMISS;
            end
            default: rc = R_BAD;
        endcase
    endtask

    // One request/response; 'hold' cycles of backpressure once the response appears.
    task automatic xact(input logic [3:0] op, input logic [31:0] k, input logic [31:0] d,
                        input int hold, output logic [4:0] rc, output logic [31:0] v,
                        output logic [31:0] ko, output int lat);
        int n = 0;
        @(negedge clock);
        while (!in_input_ready && n < 2000) begin
            @(negedge clock);
            n++;
        end
        check("req_ready", 64'(in_input_ready), 64'd1);
        in_input_valid   = 1'b1;
        in_opcode        = op;
        in_key           = k;
        in_wr_data       = d;
        out_output_ready = (hold == 0);
        @(negedge clock);
        in_input_valid = 1'b0;
        lat = 0;
        while (!out_output_valid && lat < 50) begin
            @(negedge clock);
            lat++;
        end
        rc = out_rescode;
        v  = out_val_out;
        ko = out_key;
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            check("hold_valid", 64'(out_output_valid), 64'd1);
            check("hold_code", 64'(out_rescode), 64'(rc));
            check("hold_val", 64'(out_val_out), 64'(v));
            check("hold_key", 64'(out_key), 64'(ko));
            check("hold_in_ready", 64'(in_input_ready), 64'd0);
        end
        out_output_ready = 1'b1;
    endtask

    task automatic run_dir(input string tag, input logic [3:0] op, input logic [31:0] k,
                           input logic [31:0] d, input int hold, input logic [4:0] exp_rc,
                           input logic [31:0] exp_val);
        logic [4:0]  rc, mrc;
        logic [31:0] v, ko, mv;
        int          lat;
        xact(op, k, d, hold, rc, v, ko, lat);
        check({tag, "_code"}, 64'(rc), 64'(exp_rc));
        check({tag, "_val"}, 64'(v), 64'(exp_val));
        check({tag, "_key"}, 64'(ko), 64'(k));
        check({tag, "_lat"}, 64'(lat), 64'd2);
        model_apply(op, k, d, mrc, mv);
    endtask

    initial begin
        logic [4:0]  rc, erc;
        logic [31:0] v, ev, ko, k, d;
        logic [3:0]  op;
        int          lat, n;
        logic        early_ready, saw_valid;

        reset            = 1'b1;
        in_input_valid   = 1'b0;
        in_opcode        = '0;
        in_key           = '0;
        in_wr_data       = '0;
        out_output_ready = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_in_ready", 64'(in_input_ready), 64'd0);
        check("rst_out_valid", 64'(out_output_valid), 64'd0);
        check("rst_val", 64'(out_val_out), 64'd0);
        check("rst_key", 64'(out_key), 64'd0);
        check("rst_code", 64'(out_rescode), 64'd0);
        check("rst_init_done", 64'(status_init_done), 64'd0);

        // Init sweep: exactly NE edges after reset deasserts.
        reset = 1'b0;
        early_ready = 1'b0;
        for (int c = 1; c <= int'(NE); c++) begin
            @(posedge clock);
            #1;
            if (c < int'(NE) && in_input_ready) early_ready = 1'b1;
            if (c == int'(NE) - 1) check("init_done_early", 64'(status_init_done), 64'd0);
            if (c == int'(NE)) check("init_done_edge", 64'(status_init_done), 64'd1);
        end
        check("init_ready_low", 64'(early_ready), 64'd0);

        // Basic insert / update / search.
        run_dir("ins10", OP_I, 32'd10, 32'd100, 0, R_IOK, 32'd0);
        run_dir("srch10", OP_S, 32'd10, 32'd0, 0, R_FOUND, 32'd100);
        run_dir("upd10", OP_I, 32'd10, 32'd200, 0, R_IUPD, 32'd0);
        run_dir("srch10b", OP_S, 32'd10, 32'd0, 0, R_FOUND, 32'd200);
        run_dir("srch11", OP_S, 32'd11, 32'd0, 0, R_SMISS, 32'd0);

        // Collisions in bucket 5.
        run_dir("col5", OP_I, 32'd5, 32'd1, 0, R_IOK, 32'd0);
        run_dir("col1028", OP_I, 32'd1028, 32'd2, 0, R_IOK, 32'd0);
        run_dir("col2055", OP_I, 32'd2055, 32'd3, 0, R_IOK, 32'd0);
        run_dir("col3078", OP_I, 32'd3078, 32'd4, 0, R_IOK, 32'd0);
        run_dir("full4097", OP_I, 32'd4097, 32'd5, 0, R_IFULL, 32'd0);
        run_dir("del2055", OP_D, 32'd2055, 32'd0, 0, R_DOK, 32'd0);
        run_dir("ins4097", OP_I, 32'd4097, 32'd6, 0, R_IOK, 32'd0);
        run_dir("srch2055", OP_S, 32'd2055, 32'd0, 0, R_SMISS, 32'd0);
        run_dir("srch4097", OP_S, 32'd4097, 32'd0, 0, R_FOUND, 32'd6);
        run_dir("srch1028", OP_S, 32'd1028, 32'd0, 0, R_FOUND, 32'd2);

        // Backpressure, delete miss, illegal opcode leaving the table intact.
        run_dir("bp_srch10", OP_S, 32'd10, 32'd0, 10, R_FOUND, 32'd200);
        run_dir("del77", OP_D, 32'd77, 32'd0, 0, R_DMISS, 32'd0);
        run_dir("bad7", 4'b0111, 32'd10, 32'd999, 0, R_BAD, 32'd0);
        run_dir("srch10c", OP_S, 32'd10, 32'd0, 0, R_FOUND, 32'd200);

        // Randomized traffic, biased toward a handful of colliding buckets.
        for (int t = 0; t < 400; t++) begin
            n = int'($urandom_range(0, 15));
            if (n == 0) op = 4'($urandom_range(4, 15));
            else op = 4'($urandom_range(1, 3));
            if ($urandom_range(0, 3) == 0) k = $urandom();
            else k = ($urandom_range(0, 3) << 10) | $urandom_range(0, 7);
            d = $urandom();
            model_apply(op, k, d, erc, ev);
            xact(op, k, d, int'($urandom_range(0, 3)), rc, v, ko, lat);
            check("rnd_code", 64'(rc), 64'(erc));
            check("rnd_val", 64'(v), 64'(ev));
            check("rnd_key", 64'(ko), 64'(k));
        end

        // Reset while the INSERT sits in the compare cycle.
        @(negedge clock);
        n = 0;
        while (!in_input_ready && n < 2000) begin
            @(negedge clock);
            n++;
        end
        in_input_valid = 1'b1;
        in_opcode      = OP_I;
        in_key         = 32'd10;
        in_wr_data     = 32'd55;
        @(negedge clock);
        in_input_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        mval.delete();
        bcnt.delete();
        check("rstmid_valid", 64'(out_output_valid), 64'd0);
        check("rstmid_ready", 64'(in_input_ready), 64'd0);
        check("rstmid_done", 64'(status_init_done), 64'd0);
        saw_valid = 1'b0;
        n = 0;
        while (!status_init_done && n < 1100) begin
            @(negedge clock);
            if (out_output_valid) saw_valid = 1'b1;
            n++;
        end
        check("rstmid_resweep_done", 64'(status_init_done), 64'd1);
        check("rstmid_resweep_len", 64'(n), 64'(NE));
        check("rstmid_no_resp", 64'(saw_valid), 64'd0);
        run_dir("post_rst_srch10", OP_S, 32'd10, 32'd0, 0, R_SMISS, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hash_table_bucket_engine.md
# hash_table_bucket_engine

Single-partition bucketed hash table engine with search, insert-or-update and delete. Each bucket holds a configurable number of key/value slots. Valid/ready handshakes on both the request and the response side allow backpressure. After reset the engine sweeps and clears its bucket RAM before accepting work. It is the per-PE building block that the multi-PE hash table top instantiates once per partition.

## Interface
- NUM_ENTRIES, 1024: buckets per engine; power of two, ≥ 2; IDX_W = $clog2(NUM_ENTRIES).
- NUM_SLOTS, 4: slots per bucket; ≥ 1.
- KEY_WIDTH, 32: key width.
- VAL_WIDTH, 32: value width.
- OPCODE_WIDTH, 4: opcode width.
- RESCODE_WIDTH, 5: result code width.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_input_valid  in  1  request valid.
- in_input_ready  out  1  engine can accept a request.
- in_opcode  in  OPCODE_WIDTH  0001 SEARCH, 0010 INSERT, 0011 DELETE; all other codes are illegal.
- in_key  in  KEY_WIDTH  request key.
- in_wr_data  in  VAL_WIDTH  insert value; ignored for other opcodes.
- out_output_valid  out  1  response valid.
- out_output_ready  in  1  consumer accepts the response.
- out_val_out  out  VAL_WIDTH  stored value on SEARCH_FOUND, else 0.
- out_key  out  KEY_WIDTH  echo of the request key.
- out_rescode  out  RESCODE_WIDTH  result code.
- status_init_done  out  1  high once the clear sweep has completed.

## Operation
- Rescodes: 0 NONE, 1 SEARCH_FOUND, 2 SEARCH_MISS, 3 INSERT_OK, 4 INSERT_UPDATED, 5 INSERT_FULL, 6 DELETE_OK, 7 DELETE_MISS, 8 BAD_OPCODE.
- Hash: idx = XOR of all IDX_W-bit chunks of the key, LSB chunk first; the top chunk is zero-padded. Example with IDX_W=10, key 1028: 4 ^ 1 = 5.
- Bucket word: NUM_SLOTS × {valid, key, val}.
- FSM states: INIT, IDLE, RD, CMP, RESP.
  - INIT: writes an all-zero word to one address per cycle, 0 to NUM_ENTRIES−1. After the last address it goes to IDLE and sets status_init_done.
  - IDLE: in_input_ready=1. On valid&ready, registers opcode, key and data, then goes to RD.
  - RD: drives the RAM read address with idx, then goes to CMP.
  - CMP: compares against every valid slot and writes back at most once, then goes to RESP.
  - RESP: out_output_valid=1. Goes to IDLE on out_output_ready.
- SEARCH: lowest-index valid slot with a matching key gives FOUND plus its value; otherwise MISS. No write.
- INSERT:
  - Matching valid slot: overwrite its value, return UPDATED.
  - Otherwise, free slot available: write the lowest-index free slot, return OK.
  - Otherwise: FULL, no write.
- DELETE: clear the valid bit of the matching slot and return OK; if no slot matches, return MISS.
- Illegal opcode: BAD_OPCODE, no RAM access.
  - It still passes through RD and CMP so latency stays uniform.
- Duplicate keys are impossible by construction, because insert always checks for a match first.

## Timing
- Reset values: in_input_ready 0, out_output_valid 0, out_val_out 0, out_key 0, out_rescode 0, status_init_done 0, state INIT.
- The init sweep takes exactly NUM_ENTRIES cycles after reset deasserts. in_input_ready is held low throughout.
- Accept at edge E0; RAM data is valid at E1; write-back and response register at E2. out_output_valid is high from E2.
- The response stays stable while out_output_valid=1 and out_output_ready=0.
- in_input_ready is high only in IDLE. Minimum request spacing is 4 cycles with out_output_ready tied high.
- The write at E2 precedes the earliest next read at E4, so no RAW forwarding is needed.
- Reset asserted in any state, including CMP and RESP:
  - no write-back is issued,
  - any pending response is dropped,
  - the FSM re-enters INIT and the full sweep restarts.

## Structure
- hash_table_pkg holds:
  - opcode and rescode enums,
  - the bucket slot struct typedef,
  - the hash_idx function, parametrised on IDX_W and KEY_WIDTH.
- Sub-module hash_table_bucket_ram: simple dual-port RAM, one read port and one write port, registered read (1-cycle latency), no reset on the array.
- The FSM, compare and priority-encode logic stay in the top module.

## Test plan
- Reset, then idle: all outputs 0. in_input_ready stays low for 1024 cycles; status_init_done rises exactly at cycle 1024 after reset deasserts.
- INSERT key 10 / val 100 → INSERT_OK, out_output_valid 2 cycles after accept. Then SEARCH key 10 → SEARCH_FOUND, val_out 100, out_key 10.
- INSERT key 10 / val 200 → INSERT_UPDATED. SEARCH key 10 → FOUND 200. SEARCH key 11 → SEARCH_MISS, val_out 0.
- Same-bucket collisions (all hash to idx 5):
  - INSERT keys 5, 1028, 2055, 3078 → four INSERT_OK; INSERT 4097 → INSERT_FULL.
  - DELETE 2055 → DELETE_OK; INSERT 4097 → INSERT_OK.
  - SEARCH 2055 → SEARCH_MISS; SEARCH 4097 → FOUND.
- Backpressure: hold out_output_ready low for 10 cycles → response held constant and in_input_ready low. DELETE key 77 → DELETE_MISS. Opcode 0111 → BAD_OPCODE with the table unchanged.
- Reset mid-operation: INSERT key 10, assert reset for 1 cycle while in CMP → no response emitted and the sweep restarts. After init, SEARCH 10 → SEARCH_MISS.
